// File: rtl/nn_pkg.sv
// Shared fixed-point constants and helpers for the neuron datapath stages.
// Activations and weights are Q(int).(frac); products and sums use double width.
package nn_pkg;

  localparam int DATA_WIDTH       = 16;
  localparam int WEIGHT_INT_WIDTH = 4;
  localparam int FRAC_WIDTH       = DATA_WIDTH - WEIGHT_INT_WIDTH;
  localparam int SUM_WIDTH        = 2 * DATA_WIDTH;

  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  // Valid/first/last tags travelling alongside each pipeline entry.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } flags_t;

  // Overflow only when both operands share a sign that the raw sum loses.
  function automatic logic signed [SUM_WIDTH-1:0] sat_add_fn(
    input logic signed [SUM_WIDTH-1:0] a,
    input logic signed [SUM_WIDTH-1:0] b
  );
    logic signed [SUM_WIDTH-1:0] s;
    s = a + b;
    if ((a[SUM_WIDTH-1] == b[SUM_WIDTH-1]) && (s[SUM_WIDTH-1] != a[SUM_WIDTH-1]))
      return a[SUM_WIDTH-1] ? SAT_MIN : SAT_MAX;
    return s;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the most positive/negative value
// instead of wrapping on overflow.
module sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] raw_sum;
  logic                overflow;

  assign raw_sum  = a + b;
  assign overflow = (a[W-1] == b[W-1]) && (raw_sum[W-1] != a[W-1]);
  assign y        = overflow ? (a[W-1] ? MIN_VAL : MAX_VAL) : raw_sum;

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: drives the weight memory read port, multiplies
// each activation by its weight, accumulates with saturation and adds the bias.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int numWeight      = 3,
  parameter int dataWidth      = DATA_WIDTH,
  parameter int weightIntWidth = WEIGHT_INT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [dataWidth-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          ren,
  output logic [9:0]                    radd,
  input  logic signed [dataWidth-1:0]   wout,
  input  logic signed [2*dataWidth-1:0] bias,
  output logic signed [2*dataWidth-1:0] out_data,
  output logic                          out_valid,
  output logic                          busy
);

  localparam int         SW       = 2 * dataWidth;
  localparam logic [9:0] IDX_LAST = 10'(numWeight - 1);

  generate
    if (numWeight < 1 || numWeight > 1024 || weightIntWidth < 1 || weightIntWidth >= dataWidth) begin : g_bad_params
      $error("neuron_mac: parameter out of range");
    end
  endgenerate

  logic [9:0]            idx_reg, idx_next;
  logic                  in_first, in_last;
  flags_t                s1_flags_reg, s2_flags_reg;
  logic signed [dataWidth-1:0] s1_data_reg;
  logic signed [SW-1:0]  s2_prod_reg, prod_full;
  logic                  s3_valid_reg, s3_last_reg;
  logic signed [SW-1:0]  acc_reg, acc_sum, bias_sum;
  logic signed [SW-1:0]  out_data_reg;
  logic                  out_valid_reg, busy_reg, busy_next;

  assign in_first = (idx_reg == 10'd0);
  assign in_last  = (idx_reg == IDX_LAST);

  // Weight for the activation now in S1 arrives on wout this cycle.
  assign prod_full = SW'(s1_data_reg) * SW'(wout);

  sat_add #(.W(SW)) u_acc_add (
    .a (acc_reg),
    .b (s2_prod_reg),
    .y (acc_sum)
  );

  sat_add #(.W(SW)) u_bias_add (
    .a (acc_reg),
    .b (bias),
    .y (bias_sum)
  );

  always_comb begin
    idx_next  = idx_reg;
    busy_next = 1'b0;
    if (in_valid)
      idx_next = in_last ? 10'd0 : idx_reg + 10'd1;
    // Anything still upstream of the finishing S3 entry belongs to a newer vector.
    busy_next = in_valid || (idx_reg != 10'd0) || s1_flags_reg.valid || s2_flags_reg.valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      s1_flags_reg  <= '0;
      s1_data_reg   <= '0;
      s2_flags_reg  <= '0;
      s2_prod_reg   <= '0;
      s3_valid_reg  <= 1'b0;
      s3_last_reg   <= 1'b0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      idx_reg      <= idx_next;
      s1_flags_reg <= '{valid: in_valid, first: in_first, last: in_last};
      s1_data_reg  <= in_data;
      s2_flags_reg <= s1_flags_reg;
      s2_prod_reg  <= prod_full;
      s3_valid_reg <= s2_flags_reg.valid;
      s3_last_reg  <= s2_flags_reg.valid && s2_flags_reg.last;
      if (s2_flags_reg.valid)
        acc_reg <= s2_flags_reg.first ? s2_prod_reg : acc_sum;
      out_valid_reg <= s3_valid_reg && s3_last_reg;
      if (s3_valid_reg && s3_last_reg)
        out_data_reg <= bias_sum;
      busy_reg <= busy_next;
    end
  end

  assign ren       = in_valid;
  assign radd      = idx_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: directed vectors from the test plan plus
// randomized vectors scored against a plain-arithmetic reference model.
module tb_neuron_mac;

  localparam int NW = 3;
  localparam int DW = 16;
  localparam int SW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 ren;
  logic [9:0]           radd;
  logic signed [DW-1:0] wout;
  logic signed [SW-1:0] bias;
  logic signed [SW-1:0] out_data;
  logic                 out_valid;
  logic                 busy;

  always #5 clk = ~clk;

  neuron_mac #(.numWeight(NW), .dataWidth(DW), .weightIntWidth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .ren       (ren),
    .radd      (radd),
    .wout      (wout),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  // Weight memory with one-cycle registered read.
  logic [DW-1:0] wmem [NW];
  always @(posedge clk) if (ren) wout <= wmem[int'(radd)];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [SW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t          exp_q[$];
  logic          busy_log[$];
  logic [SW-1:0] last_data;

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [SW-1:0] model(input logic [DW-1:0] x [NW]);
    longint acc, p;
    acc = 0;
    for (int k = 0; k < NW; k++) begin
      p   = longint'($signed(x[k])) * longint'($signed(wmem[k]));
      acc = (k == 0) ? p : clamp(acc + p);
    end
    acc = clamp(acc + longint'($signed(bias)));
    return acc[SW-1:0];
  endfunction

  // One clock: score any output at the negedge, then move to just after the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      n_checks++;
      busy_log.push_back(busy);
      last_data = out_data;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid cyc=%0d out_data=%h required=no pulse", cyc, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out_sum out_data=%h at cyc %0d, required %h at cyc %0d", out_data, cyc, e.data, e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      e = exp_q.pop_front();
      $display("FAIL missing_out_valid cyc=%0d out_valid=0 required pulse with %h", cyc, e.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [DW-1:0] w2);
    wmem[0] = w0;
    wmem[1] = w1;
    wmem[2] = w2;
  endtask

  task automatic send_vector(input logic [DW-1:0] x [NW], input int gap);
    for (int k = 0; k < NW; k++) begin
      in_data  = x[k];
      in_valid = 1'b1;
      n_checks++;
      if (radd !== 10'(k)) begin
        n_fail++;
        $display("FAIL radd_seq radd=%0d required %0d", radd, k);
      end
      if (k == NW - 1) exp_q.push_back('{model(x), cyc + 4});
      tick();
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        n_checks++;
        if (radd !== 10'((k + 1) % NW)) begin
          n_fail++;
          $display("FAIL radd_hold radd=%0d required %0d", radd, (k + 1) % NW);
        end
        tick();
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic check_last(input string name, input logic [SW-1:0] req);
    n_checks++;
    if (last_data !== req) begin
      n_fail++;
      $display("FAIL %s out_data=%h required %h", name, last_data, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0;
    set_w(16'h0, 16'h0, 16'h0);
    repeat (3) tick();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data got %h required 0", out_data); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b required 0", busy); end
    if (radd !== 10'd0)     begin n_fail++; $display("FAIL reset_radd got %0d required 0", radd); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] v [NW];
    v = '{16'h1000, 16'h2000, 16'h1000};
    set_w(16'h1000, 16'h1000, 16'hF000);
    bias = '0;
    busy_log.delete();
    send_vector(v, 0);
    n_checks += 2;
    if (radd !== 10'd0) begin n_fail++; $display("FAIL basic_radd_wrap got %0d required 0", radd); end
    if (busy !== 1'b1)  begin n_fail++; $display("FAIL basic_busy_inflight got %b required 1", busy); end
    drain();
    check_last("basic_sum", 32'h02000000);
    n_checks++;
    if (busy_log.size() != 1 || busy_log[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_at_out pulses=%0d required 1 pulse with busy=0", busy_log.size());
    end
  endtask

  task automatic test_bias();
    logic [DW-1:0] v [NW];
    v = '{16'h1000, 16'h2000, 16'h1000};
    set_w(16'h1000, 16'h1000, 16'hF000);
    bias = 32'h01000000;
    send_vector(v, 0);
    drain();
    check_last("bias_pos", 32'h03000000);
    bias = 32'hFE000000;
    send_vector(v, 0);
    drain();
    check_last("bias_neg", 32'h00000000);
  endtask

  task automatic test_saturation();
    logic [DW-1:0] v [NW];
    v = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    bias = '0;
    set_w(16'h7FFF, 16'h7FFF, 16'h7FFF);
    send_vector(v, 0);
    drain();
    check_last("sat_pos", 32'h7FFFFFFF);
    set_w(16'h8000, 16'h8000, 16'h8000);
    send_vector(v, 0);
    drain();
    check_last("sat_neg", 32'h80000000);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v1 [NW];
    logic [DW-1:0] v2 [NW];
    v1 = '{16'h1000, 16'h2000, 16'h1000};
    v2 = '{16'h2000, 16'h4000, 16'h2000};
    set_w(16'h1000, 16'h1000, 16'hF000);
    bias = '0;
    busy_log.delete();
    send_vector(v1, 0);
    send_vector(v2, 0);
    drain();
    check_last("b2b_second_sum", 32'h04000000);
    n_checks++;
    if (busy_log.size() != 2 || busy_log[0] !== 1'b1 || busy_log[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy pulses=%0d required 2 pulses with busy 1 then 0", busy_log.size());
    end
  endtask

  task automatic test_gapped();
    logic [DW-1:0] v [NW];
    v = '{16'h1000, 16'h2000, 16'h1000};
    set_w(16'h1000, 16'h1000, 16'hF000);
    bias = '0;
    send_vector(v, 2);
    drain();
    check_last("gapped_sum", 32'h02000000);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v [NW];
    v = '{16'h1000, 16'h2000, 16'h1000};
    set_w(16'h1000, 16'h1000, 16'hF000);
    bias = '0;
    in_valid = 1'b1; in_data = 16'h1000; tick();
    in_data = 16'h2000; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    n_checks += 2;
    if (radd !== 10'd0) begin n_fail++; $display("FAIL rstmid_radd got %0d required 0", radd); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL rstmid_busy got %b required 0", busy); end
    repeat (5) tick();
    send_vector(v, 0);
    drain();
    check_last("rstmid_sum", 32'h02000000);
  endtask

  task automatic test_random();
    logic [DW-1:0] v [NW];
    for (int b = 0; b < 2; b++) begin
      bias = $urandom();
      for (int n = 0; n < 15; n++) begin
        set_w(DW'($urandom()), DW'($urandom()), DW'($urandom()));
        for (int k = 0; k < NW; k++) v[k] = DW'($urandom());
        send_vector(v, $urandom_range(0, 2));
      end
      drain();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_bias();
    test_saturation();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Per-neuron multiply-accumulate stage directly downstream of the neuron's weight memory.
- Streams one input activation per valid cycle and drives the weight memory read port in lockstep.
- Multiplies each activation by the returned weight and accumulates the products with saturation.
- After numWeight inputs, adds the neuron bias and emits one pre-activation sum to the activation stage.

Parameters:
- numWeight, 3, inputs per vector; also the weight memory depth (1..1024).
- dataWidth, 16, width of activations and weights (signed two's complement).
- weightIntWidth, 4, integer bits of the Q format (fraction bits = dataWidth-weightIntWidth).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  dataWidth  signed activation.
- in_valid  in  1  in_data valid this cycle.
- ren  out  1  weight memory read enable; combinationally equal to in_valid.
- radd  out  10  weight memory read address; registered index counter.
- wout  in  dataWidth  weight from memory, valid one cycle after ren.
- bias  in  2*dataWidth  signed bias, already aligned to product format; static while a vector is in flight.
- out_data  out  2*dataWidth  signed saturated sum.
- out_valid  out  1  single-cycle strobe marking out_data valid.
- busy  out  1  high from the first accepted input until out_valid.

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, radd=0. All pipeline valids and the accumulator are cleared.
- Reset mid-vector discards the partial vector. No out_valid is produced for it.
- Index counter (radd):
  - Increments on each in_valid.
  - Wraps numWeight-1 -> 0; the wrapping input is marked "last".
  - No gaps are required between inputs; idle cycles just stall the counter.
- Pipeline, with in_valid sampled at cycle t:
  - S1 (t+1): register in_data and the valid/last flags; wout is valid in this cycle.
  - S2 (t+2): register the full-precision signed product in_data*wout (2*dataWidth bits, Q(2*weightIntWidth).(2*fraction)).
  - S3 (t+3): accumulator.
    - First product of a vector loads the accumulator.
    - Later products use a saturating add.
  - S4 (t+4): when the S3 entry was "last", register the saturating add of accumulator and bias into out_data and pulse out_valid.
- Latency: out_valid is high exactly 4 cycles after the cycle the last in_valid of a vector was sampled. out_data holds until the next out_valid.
- Saturating add:
  - Overflow occurs when both operands have the same sign and the result sign differs.
  - Positive overflow clamps to 0x7FFF...F; negative overflow clamps to 0x8000...0.
  - Clamping applies at every accumulate step and at the bias add.
- Back-to-back vectors: the "first" flag on the next vector's product reloads the accumulator in the same cycle the previous sum moves to S4. There are no bubbles; throughput is one input per cycle.
- numWeight=1: every input is both first and last.
- busy:
  - Set on the first in_valid of a vector.
  - Cleared in the out_valid cycle, unless a new vector has already started, in which case it stays high.
- in_valid is never ignored. There is no backpressure; the activation stage always accepts out_valid.

Decomposition:
- Shared package nn_pkg:
  - dataWidth and weightIntWidth defaults.
  - Derived fraction-bit constant.
  - Saturation max/min constants for 2*dataWidth.
  - Saturating-add function used by the activation and pooling stages.
- One sub-module: sat_add.
  - Parameterised width; combinational signed add with overflow clamp.
  - Instantiated twice: accumulate and bias.
- Counter, flags and pipeline registers stay in neuron_mac.

Test Plan:
- Basic sum: numWeight=3, weights {0x1000,0x1000,0xF000}, inputs {0x1000,0x2000,0x1000} back-to-back, bias=0 -> one out_valid 4 cycles after the 3rd input, out_data=0x02000000. radd sequence 0,1,2 then 0.
- Bias: same vector with bias=0x01000000 -> out_data=0x03000000. Bias=0xFE000000 -> out_data=0x00000000.
- Saturation: all weights and inputs 0x7FFF -> out_data=0x7FFFFFFF. Weights 0x8000 with inputs 0x7FFF -> out_data=0x80000000. Neither result wraps.
- Back-to-back: two vectors with no idle cycle; second vector's inputs scaled by 2 -> two out_valid pulses 3 cycles apart (0x02000000, 0x04000000). busy stays high between them.
- Gapped input: idle cycles between inputs -> same result as the basic case. radd holds during gaps. out_valid 4 cycles after the last input.
- Reset mid-vector: assert rst after 2 inputs, then send a full vector -> no out_valid from the partial vector, radd restarts at 0, result 0x02000000.
